// File: rtl/dsi_arb_pkg.sv
// Shared types and constants for the DSI lane arbiter: FSM states, port
// indices and the one-hot grant encoding.
package dsi_arb_pkg;

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_IDLE     = 3'd1,
    ST_START    = 3'd2,
    ST_XFER     = 3'd3,
    ST_FIN      = 3'd4,
    ST_GAP      = 3'd5
  } arb_state_t;

  localparam int PORT_HS = 0;
  localparam int PORT_LP = 1;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_HS   = 2'b01;
  localparam logic [1:0] GRANT_LP   = 2'b10;

  // Resolve a two-way request into a one-hot grant, favouring the port that
  // did not win last time when both ask together.
  function automatic logic [1:0] rr_pick(input logic req_hs, input logic req_lp,
                                         input logic last_lp);
    logic [1:0] pick;
    if (req_hs && req_lp) begin
      pick = last_lp ? GRANT_HS : GRANT_LP;
    end else if (req_hs) begin
      pick = GRANT_HS;
    end else if (req_lp) begin
      pick = GRANT_LP;
    end else begin
      pick = GRANT_NONE;
    end
    return pick;
  endfunction

endpackage

// File: rtl/dsi_rr_arbiter2.sv
// Two-way round-robin decision between the HS and LP ports. The last-grant
// register starts at LP so HS wins the first tie after reset.
module dsi_rr_arbiter2
  import dsi_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_hs,
  input  logic       req_lp,
  input  logic       accept,
  output logic [1:0] winner
);

  logic last_lp;

  // Current winner from live requests and the remembered last owner.
  always_comb begin
    winner = rr_pick(req_hs, req_lp, last_lp);
  end

  // Remember who was granted, only when the owner actually latches it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_lp <= 1'b1;
    end else if (accept && (winner != GRANT_NONE)) begin
      last_lp <= winner[PORT_LP];
    end else begin
      last_lp <= last_lp;
    end
  end

endmodule

// File: rtl/dsi_lane_arbiter.sv
// Arbitrates the HS and LP byte sources onto one DSI lane with an enforced
// idle gap. Define DSI_ARB_WATCHDOG_EN to build the lane-progress watchdog.
module dsi_lane_arbiter
  import dsi_arb_pkg::*;
#(
  parameter int GAP_CYCLES  = 4,
  parameter int WDOG_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       hs_req,
  input  logic [7:0] hs_data,
  input  logic       hs_last,
  output logic       hs_rd,
  input  logic       lp_req,
  input  logic [7:0] lp_data,
  input  logic       lp_last,
  output logic       lp_rd,
  input  logic       lane_idle,
  input  logic       lane_data_rqst,
  output logic       lane_lines_enable,
  output logic       lane_start_rqst,
  output logic       lane_mode_lp,
  output logic       lane_fin_rqst,
  output logic [7:0] lane_data,
  output logic [1:0] grant,
  output logic       wdog_err
);

  if ((GAP_CYCLES < 1) || (GAP_CYCLES > 255)) begin : g_gap_range
    $error("GAP_CYCLES must lie in 1..255");
  end
  if ((WDOG_CYCLES < 2) || (WDOG_CYCLES > 255)) begin : g_wdog_range
    $error("WDOG_CYCLES must lie in 2..255");
  end

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  arb_state_t state;
  logic [7:0] gap_cnt;
  logic [7:0] data_hold;
  logic [1:0] winner;
  logic       rr_accept;
  logic [7:0] sel_data;
  logic       sel_last;
  logic       consume;
  logic       wdog_expired;

  assign rr_accept = (state == ST_IDLE) && enable;

  dsi_rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req_hs (hs_req),
    .req_lp (lp_req),
    .accept (rr_accept),
    .winner (winner)
  );

  // Data path to the lane: live mux while streaming, held last byte otherwise.
  always_comb begin
    sel_data = grant[PORT_LP] ? lp_data : hs_data;
    sel_last = grant[PORT_LP] ? lp_last : hs_last;
    consume  = (state == ST_XFER) && enable && lane_data_rqst;
    hs_rd    = consume && grant[PORT_HS];
    lp_rd    = consume && grant[PORT_LP];
    case (state)
      ST_XFER: begin
        lane_data     = sel_data;
        lane_fin_rqst = sel_last;
      end
      ST_FIN: begin
        lane_data     = data_hold;
        lane_fin_rqst = 1'b1;
      end
      default: begin
        lane_data     = data_hold;
        lane_fin_rqst = 1'b0;
      end
    endcase
  end

  // Transaction sequencer with registered grant, start pulse and mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_DISABLED;
      grant             <= GRANT_NONE;
      lane_start_rqst   <= 1'b0;
      lane_mode_lp      <= 1'b0;
      lane_lines_enable <= 1'b0;
      data_hold         <= 8'h00;
      gap_cnt           <= 8'h00;
    end else begin
      lane_lines_enable <= enable;
      lane_start_rqst   <= 1'b0;
      if (!enable) begin
        state <= ST_DISABLED;
        grant <= GRANT_NONE;
      end else begin
        case (state)
          ST_DISABLED: begin
            if (lane_idle) begin
              state <= ST_IDLE;
            end
          end
          ST_IDLE: begin
            if (winner != GRANT_NONE) begin
              grant           <= winner;
              lane_mode_lp    <= winner[PORT_LP];
              lane_start_rqst <= 1'b1;
              state           <= ST_START;
            end
          end
          ST_START: begin
            state <= ST_XFER;
          end
          ST_XFER: begin
            if (lane_data_rqst) begin
              data_hold <= sel_data;
              if (sel_last) begin
                state <= ST_FIN;
              end
            end else if (wdog_expired) begin
              state   <= ST_GAP;
              grant   <= GRANT_NONE;
              gap_cnt <= GAP_LOAD;
            end
          end
          ST_FIN: begin
            if (lane_idle || wdog_expired) begin
              state   <= ST_GAP;
              grant   <= GRANT_NONE;
              gap_cnt <= GAP_LOAD;
            end
          end
          ST_GAP: begin
            if (gap_cnt == 8'd0) begin
              state <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt - 8'd1;
            end
          end
          default: begin
            state <= ST_DISABLED;
            grant <= GRANT_NONE;
          end
        endcase
      end
    end
  end

`ifdef DSI_ARB_WATCHDOG_EN
  localparam logic [7:0] WDOG_LOAD = 8'(WDOG_CYCLES);
  logic [7:0] wdog_cnt;

  // Expiry: budget exhausted while the lane makes no progress.
  always_comb begin
    wdog_expired = (wdog_cnt == 8'd0) &&
                   (((state == ST_XFER) && !lane_data_rqst) ||
                    ((state == ST_FIN) && !lane_idle));
  end

  // Progress budget, reloaded on start and on every byte the lane takes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt <= 8'd0;
      wdog_err <= 1'b0;
    end else if (!enable) begin
      wdog_cnt <= 8'd0;
      wdog_err <= 1'b0;
    end else begin
      case (state)
        ST_START: wdog_cnt <= WDOG_LOAD;
        ST_XFER, ST_FIN: begin
          if ((state == ST_XFER) && lane_data_rqst) begin
            wdog_cnt <= WDOG_LOAD;
          end else if (wdog_expired) begin
            wdog_err <= 1'b1;
          end else if (wdog_cnt != 8'd0) begin
            wdog_cnt <= wdog_cnt - 8'd1;
          end else begin
            wdog_cnt <= wdog_cnt;
          end
        end
        default: wdog_cnt <= wdog_cnt;
      endcase
    end
  end
`else
  assign wdog_expired = 1'b0;
  assign wdog_err     = 1'b0;
`endif

endmodule

// File: tb/tb_dsi_lane_arbiter.sv
// Randomized bench for dsi_lane_arbiter: bench-side byte sources and lane,
// checked against a transaction-level model of the arbitration rules.
module tb_dsi_lane_arbiter;

  localparam int GAP = 4;
  localparam int PH_DIS = 0, PH_IDLE = 1, PH_START = 2, PH_XFER = 3, PH_FIN = 4, PH_GAP = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic hs_req = 1'b0, hs_last = 1'b0, lp_req = 1'b0, lp_last = 1'b0;
  logic [7:0] hs_data = 8'h00, lp_data = 8'h00;
  logic lane_idle = 1'b1, lane_data_rqst = 1'b0;
  logic hs_rd, lp_rd, lane_lines_enable, lane_start_rqst, lane_mode_lp, lane_fin_rqst, wdog_err;
  logic [7:0] lane_data;
  logic [1:0] grant;

  always #5 clk = ~clk;

  dsi_lane_arbiter #(.GAP_CYCLES(GAP), .WDOG_CYCLES(255)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .hs_req(hs_req), .hs_data(hs_data), .hs_last(hs_last), .hs_rd(hs_rd),
    .lp_req(lp_req), .lp_data(lp_data), .lp_last(lp_last), .lp_rd(lp_rd),
    .lane_idle(lane_idle), .lane_data_rqst(lane_data_rqst),
    .lane_lines_enable(lane_lines_enable), .lane_start_rqst(lane_start_rqst),
    .lane_mode_lp(lane_mode_lp), .lane_fin_rqst(lane_fin_rqst),
    .lane_data(lane_data), .grant(grant), .wdog_err(wdog_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: one pending packet per port, current phase and owner.
  logic [7:0] hs_q[$];
  logic [7:0] lp_q[$];
  int owner_log[$];
  int ph = PH_DIS;
  int owner = 0;
  int last_owner = 1;
  int gap_left = 0;
  int rd_cnt[2];
  int fin_cycles = 0;
  logic [7:0] fin_byte = 8'h00;
  logic prev_en = 1'b0;
  bit model_on = 1'b1;
  bit auto_gen = 1'b0;
  bit rand_dis = 1'b0;
  bit en_drive = 1'b1;
  int p_rqst = 60, p_idle = 50, p_gen = 30;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic gen_packet(input int port);
    int len = $urandom_range(4, 1);
    for (int i = 0; i < len; i++) begin
      if (port == 0) hs_q.push_back(8'($urandom));
      else           lp_q.push_back(8'($urandom));
    end
  endtask

  // One lane cycle as the spec describes it, in terms of phases and packets.
  task automatic model_cycle();
    int nxt = ph;
    bit busy = (ph == PH_START) || (ph == PH_XFER) || (ph == PH_FIN);
    bit consume = (ph == PH_XFER) && enable && lane_data_rqst;
    logic [7:0] exp_d;
    bit exp_last;
    check_eq("grant", grant, busy ? (owner == 1 ? 2'b10 : 2'b01) : 2'b00);
    check_eq("start_rqst", lane_start_rqst, ph == PH_START);
    check_eq("hs_rd", hs_rd, consume && (owner == 0));
    check_eq("lp_rd", lp_rd, consume && (owner == 1));
    check_eq("lines_enable", lane_lines_enable, prev_en);
    check_eq("wdog_err_quiet", wdog_err, 1'b0);
    if (busy) check_eq("mode_lp", lane_mode_lp, owner[0]);
    case (ph)
      PH_DIS: if (lane_idle) nxt = PH_IDLE;
      PH_IDLE: begin
        if (hs_req || lp_req) begin
          owner = (hs_req && lp_req) ? (last_owner == 1 ? 0 : 1) : (hs_req ? 0 : 1);
          nxt = PH_START;
        end
      end
      PH_START: begin
        last_owner = owner;
        owner_log.push_back(owner);
        nxt = PH_XFER;
      end
      PH_XFER: begin
        if (owner == 1) begin exp_d = lp_q[0]; exp_last = (lp_q.size() == 1); end
        else            begin exp_d = hs_q[0]; exp_last = (hs_q.size() == 1); end
        check_eq("xfer_data", lane_data, exp_d);
        check_eq("xfer_fin", lane_fin_rqst, exp_last);
        if (consume) begin
          if (owner == 1) void'(lp_q.pop_front()); else void'(hs_q.pop_front());
          rd_cnt[owner]++;
          if (exp_last) begin fin_byte = exp_d; nxt = PH_FIN; end
        end
      end
      PH_FIN: begin
        fin_cycles++;
        check_eq("fin_rqst", lane_fin_rqst, 1'b1);
        check_eq("fin_data", lane_data, fin_byte);
        if (lane_idle) begin nxt = PH_GAP; gap_left = GAP; end
      end
      PH_GAP: begin
        check_eq("gap_fin", lane_fin_rqst, 1'b0);
        gap_left--;
        if (gap_left == 0) nxt = PH_IDLE;
      end
      default: ;
    endcase
    if (!enable) nxt = PH_DIS;
    prev_en = enable;
    ph = nxt;
  endtask

  // Drive one cycle of source/lane stimulus on the falling edge, then check.
  task automatic step();
    @(negedge clk);
    if (auto_gen) begin
      if (hs_q.size() == 0 && $urandom_range(99) < p_gen) gen_packet(0);
      if (lp_q.size() == 0 && $urandom_range(99) < p_gen) gen_packet(1);
    end
    enable = (rand_dis && $urandom_range(199) == 0) ? 1'b0 : en_drive;
    hs_req = (hs_q.size() != 0);
    lp_req = (lp_q.size() != 0);
    if (hs_req) hs_data = hs_q[0]; else hs_data = 8'($urandom);
    if (lp_req) lp_data = lp_q[0]; else lp_data = 8'($urandom);
    hs_last = (hs_q.size() == 1);
    lp_last = (lp_q.size() == 1);
    lane_data_rqst = ($urandom_range(99) < p_rqst);
    lane_idle = (ph == PH_FIN) ? ($urandom_range(99) < p_idle) : 1'b1;
    #1;
    if (model_on) model_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_grant"}, grant, 2'b00);
    check_eq({tag, "_start"}, lane_start_rqst, 1'b0);
    check_eq({tag, "_fin"}, lane_fin_rqst, 1'b0);
    check_eq({tag, "_data"}, lane_data, 8'h00);
    check_eq({tag, "_mode"}, lane_mode_lp, 1'b0);
    check_eq({tag, "_lines"}, lane_lines_enable, 1'b0);
    check_eq({tag, "_wdog"}, wdog_err, 1'b0);
    check_eq({tag, "_rd"}, {hs_rd, lp_rd}, 2'b00);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; hs_req = 1'b0; lp_req = 1'b0;
    lane_data_rqst = 1'b1; lane_idle = 1'b1;
    hs_q.delete(); lp_q.delete(); owner_log.delete();
    ph = PH_DIS; last_owner = 1; prev_en = 1'b0; rd_cnt[0] = 0; rd_cnt[1] = 0;
    model_on = 1'b1; auto_gen = 1'b0; rand_dis = 1'b0; en_drive = 1'b1;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int limit);
    int k = 0;
    bit done;
    while (!(ph == PH_IDLE && hs_q.size() == 0 && lp_q.size() == 0) && k < limit) begin
      step();
      k++;
    end
    done = (ph == PH_IDLE && hs_q.size() == 0 && lp_q.size() == 0);
    check_eq({tag, "_done"}, done, 1'b1);
  endtask

  initial begin
    int k;
    int n_stall;
    bit got;
    reset_dut();

    // Tie from reset: HS, then LP, then HS again on a second tie.
    hs_q = '{8'h01, 8'h02}; lp_q = '{8'h81};
    drain("tie1", 200);
    hs_q = '{8'h03}; lp_q = '{8'h83, 8'h84};
    drain("tie2", 200);
    check_eq("tie_count", owner_log.size(), 4);
    if (owner_log.size() == 4) begin
      check_eq("tie_first", owner_log[0], 0);
      check_eq("tie_second", owner_log[1], 1);
      check_eq("tie_repeat", owner_log[2], 0);
    end

    // HS only, three bytes.
    rd_cnt[0] = 0; rd_cnt[1] = 0; p_rqst = 70;
    hs_q = '{8'h11, 8'h22, 8'h33};
    drain("hs3", 200);
    check_eq("hs3_rd_count", rd_cnt[0], 3);
    check_eq("hs3_lp_rd_count", rd_cnt[1], 0);
    check_eq("hs3_fin_byte", fin_byte, 8'h33);

    // LP single byte with a slow lane in FIN.
    rd_cnt[0] = 0; rd_cnt[1] = 0; fin_cycles = 0; p_idle = 15;
    lp_q = '{8'hA5};
    drain("lp1", 300);
    check_eq("lp1_rd_count", rd_cnt[1], 1);
    check_eq("lp1_fin_byte", fin_byte, 8'hA5);
    check_eq("lp1_owner", owner_log[owner_log.size() - 1], 1);
    check_eq("lp1_fin_held", fin_cycles >= 1, 1'b1);

    // Random traffic with occasional enable drops.
    auto_gen = 1'b1; rand_dis = 1'b1;
    for (int seg = 0; seg < 6; seg++) begin
      p_rqst = $urandom_range(100, 30);
      p_idle = $urandom_range(100, 20);
      p_gen  = $urandom_range(60, 5);
      for (int i = 0; i < 500; i++) step();
    end
    auto_gen = 1'b0; rand_dis = 1'b0;
    drain("random", 400);

    // Enable dropped in the middle of an HS transfer.
    reset_dut();
    p_rqst = 100;
    hs_q = '{8'h41, 8'h42, 8'h43, 8'h44};
    k = 0;
    while (!(ph == PH_XFER && hs_q.size() < 4) && k < 50) begin step(); k++; end
    check_eq("abort_reached_xfer", ph == PH_XFER, 1'b1);
    en_drive = 1'b0;
    step();
    check_eq("abort_no_rd", {hs_rd, lp_rd}, 2'b00);
    step();
    check_eq("abort_grant", grant, 2'b00);
    check_eq("abort_lines", lane_lines_enable, 1'b0);
    en_drive = 1'b1;
    drain("abort_resume", 200);

    // Asynchronous reset in the middle of an LP transfer.
    lp_q = '{8'h91, 8'h92, 8'h93, 8'h94};
    k = 0;
    while (!(ph == PH_XFER && lp_q.size() < 4) && k < 50) begin step(); k++; end
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    reset_dut();

    // Stalled lane: watchdog abort when built, otherwise an indefinite wait.
    p_rqst = 0;
    hs_q = '{8'h55, 8'h66};
    k = 0;
    while (ph != PH_XFER && k < 20) begin step(); k++; end
    model_on = 1'b0;
    n_stall = 0; got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      step();
      if (wdog_err) got = 1'b1; else n_stall++;
    end
`ifdef DSI_ARB_WATCHDOG_EN
    check_eq("wdog_fired", got, 1'b1);
    check_eq("wdog_latency_ok", (n_stall >= 255) && (n_stall <= 257), 1'b1);
    check_eq("wdog_gap_grant", grant, 2'b00);
    check_eq("wdog_no_rd", hs_rd, 1'b0);
    step();
    check_eq("wdog_sticky", wdog_err, 1'b1);
    en_drive = 1'b0;
    step();
    step();
    check_eq("wdog_cleared", wdog_err, 1'b0);
`else
    check_eq("nowdog_err", got, 1'b0);
    check_eq("nowdog_grant", grant, 2'b01);
    check_eq("nowdog_fin", lane_fin_rqst, 1'b0);
    check_eq("nowdog_data", lane_data, 8'h55);
`endif
    reset_dut();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dsi_lane_arbiter.md
DSI_LANE_ARBITER -- requirements
Module: dsi_lane_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 4, minimum idle cycles between consecutive lane transactions (range 1..255).
REQ-002 SHALL have parameter WDOG_CYCLES, default 255, maximum cycles without lane progress before abort (range 2..255, 8-bit).
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 Ports, in order:
 - clk  in  1  clock; all logic on rising edge
 - rst  in  1  asynchronous active-high reset
 - enable  in  1  arbiter enable; forwarded as lane_lines_enable
 - hs_req  in  1  port 0 (HS) transaction request; level, held until last byte read
 - hs_data  in  8  port 0 current byte
 - hs_last  in  1  port 0 current byte is final
 - hs_rd  out  1  port 0 byte consumed pulse
 - lp_req / lp_data / lp_last / lp_rd  in/in/in/out  1/8/1/1  port 1 (LP) equivalents
 - lane_idle  in  1  lane FSM is in its idle state
 - lane_data_rqst  in  1  lane consumes lane_data this cycle
 - lane_lines_enable  out  1  lane enable
 - lane_start_rqst  out  1  one-cycle transaction start
 - lane_mode_lp  out  1  0 = HS, 1 = LP; valid with lane_start_rqst, held through transaction
 - lane_fin_rqst  out  1  final-byte marker to lane
 - lane_data  out  8  byte to lane
 - grant  out  2  one-hot current owner {lp,hs}; 0 when none
 - wdog_err  out  1  sticky watchdog abort flag

Function
REQ-005 States: DISABLED, IDLE, START, XFER, FIN, GAP.
REQ-006 DISABLED -> IDLE when enable=1 and lane_idle=1; any state -> DISABLED on enable=0 (abort, grant cleared, no further rd pulses).
REQ-007 IDLE: if hs_req or lp_req, latch winner into grant, -> START; else stay.
REQ-008 Arbitration: single requester wins; both requesting -> port not granted last (round-robin); last-grant register resets to LP so HS wins the first tie.
REQ-009 START: exactly one cycle, lane_start_rqst=1, lane_mode_lp=grant[1]; -> XFER.
REQ-010 XFER: lane_data = granted port data (combinational mux); *_rd = lane_data_rqst for granted port only; lane_fin_rqst = granted port last flag.
REQ-011 XFER -> FIN on cycle where lane_data_rqst=1 and granted last=1; that byte is consumed (rd pulses).
REQ-012 FIN: lane_fin_rqst held 1, no rd pulses, lane_data held; -> GAP when lane_idle=1.
REQ-013 GAP: grant cleared, counter loaded GAP_CYCLES-1 on entry, decrements; -> IDLE at 0 (exactly GAP_CYCLES cycles in GAP).
REQ-014 lane_data_rqst outside XFER is ignored; rd outputs are 0 in all states except XFER.
REQ-015 Requests deasserted mid-XFER are ignored; transaction ends only via last byte, watchdog, or enable=0.

Reset
REQ-016 On rst: state DISABLED, grant=0, last-grant=LP, all pulses 0, lane_data=0, lane_mode_lp=0, lane_lines_enable=0, wdog_err=0, counters 0.
REQ-017 rst mid-transaction SHALL return all outputs to reset values in the same cycle (asynchronous).

Configuration
REQ-018 Macro DSI_ARB_WATCHDOG_EN defined: 8-bit counter reloaded on START, on every consumed byte and on FIN entry; counts down in XFER/FIN; at 0 sets wdog_err, forces state GAP; wdog_err cleared only by rst or enable=0.
REQ-019 Macro undefined: no counter logic, wdog_err tied 0, XFER/FIN wait indefinitely.

Structure
REQ-020 Package dsi_arb_pkg SHALL hold the state enum, port index constants (PORT_HS=0, PORT_LP=1) and grant encoding.
REQ-021 Sub-module dsi_rr_arbiter2 SHALL implement the 2-way round-robin decision and last-grant register.

Verification
REQ-022 HS only: hs_req with 3 bytes 0x11,0x22,0x33(last) -> start pulse with mode_lp=0, hs_rd 3 pulses, fin_rqst with 0x33, GAP of 4 cycles.
REQ-023 Both requesting from reset -> HS granted first, LP second after GAP; repeat tie -> HS again.
REQ-024 LP single byte 0xA5 last -> mode_lp=1, one lp_rd, FIN held until lane_idle=1.
REQ-025 enable dropped mid-XFER -> DISABLED next cycle, grant=0, lane_lines_enable=0, no rd pulses.
REQ-026 With DSI_ARB_WATCHDOG_EN, lane_data_rqst held 0 for 255 cycles in XFER -> wdog_err=1, state GAP; without macro -> stays XFER.
